// File: rtl/position_update_if.sv
// Requester/arbiter bundle for the shared plotter position register.
interface position_update_if #(
  parameter int NUM_REQ    = 3,
  parameter int POS_X_BITS = 12,
  parameter int POS_Y_BITS = 12
);
  logic [NUM_REQ-1:0]            req_update;
  logic [NUM_REQ*POS_X_BITS-1:0] req_x;
  logic [NUM_REQ*POS_Y_BITS-1:0] req_y;
  logic                          hold;
  logic                          home;
  logic [NUM_REQ-1:0]            ack;
  logic [POS_X_BITS-1:0]         cur_x;
  logic [POS_Y_BITS-1:0]         cur_y;
  logic                          out_update;
  logic                          clamped;

  modport master (
    output req_update, req_x, req_y, hold, home,
    input  ack, cur_x, cur_y, out_update, clamped
  );

  modport slave (
    input  req_update, req_x, req_y, hold, home,
    output ack, cur_x, cur_y, out_update, clamped
  );
endinterface

// File: rtl/position_update_arbiter.sv
// Round-robin arbiter committing clamped position updates from NUM_REQ requesters
// into the single current-position register; all outputs registered.
module position_update_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int POS_X_BITS = 12,
  parameter int POS_Y_BITS = 12,
  parameter int MAX_X      = 4095,
  parameter int MAX_Y      = 4095
) (
  input  logic               clk,
  input  logic               reset,
  position_update_if.slave   bus
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [POS_X_BITS-1:0] MAX_X_V = POS_X_BITS'(MAX_X);
  localparam logic [POS_Y_BITS-1:0] MAX_Y_V = POS_Y_BITS'(MAX_Y);

  logic [NUM_REQ-1:0]    ack_q;
  logic [PTR_W-1:0]      rr_q;
  logic [POS_X_BITS-1:0] cur_x_q;
  logic [POS_Y_BITS-1:0] cur_y_q;
  logic                  upd_q;
  logic                  clp_q;

  logic [NUM_REQ-1:0]    eligible;
  logic                  found_hi, found_lo, found;
  logic [PTR_W-1:0]      win_hi, win_lo, win;
  logic [POS_X_BITS-1:0] sel_x;
  logic [POS_Y_BITS-1:0] sel_y;
  logic                  sat_x, sat_y;

  assign eligible = bus.req_update & ~ack_q & {NUM_REQ{~bus.hold & ~bus.home}};

  // Wrapping search split in two passes: first eligible at/after rr, else first overall.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (eligible[i] && !found_hi && (i >= 32'(rr_q))) begin
        found_hi = 1'b1;
        win_hi   = PTR_W'(i);
      end
      if (eligible[i] && !found_lo) begin
        found_lo = 1'b1;
        win_lo   = PTR_W'(i);
      end
    end
    found = found_hi | found_lo;
    win   = found_hi ? win_hi : win_lo;
  end

  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win == PTR_W'(i)) begin
        sel_x = bus.req_x[i*POS_X_BITS +: POS_X_BITS];
        sel_y = bus.req_y[i*POS_Y_BITS +: POS_Y_BITS];
      end
    end
    sat_x = (sel_x > MAX_X_V);
    sat_y = (sel_y > MAX_Y_V);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q   <= '0;
      rr_q    <= '0;
      cur_x_q <= '0;
      cur_y_q <= '0;
      upd_q   <= 1'b0;
      clp_q   <= 1'b0;
    end else begin
      ack_q <= '0;
      upd_q <= 1'b0;
      clp_q <= 1'b0;
      if (bus.home) begin
        cur_x_q <= '0;
        cur_y_q <= '0;
        upd_q   <= 1'b1;
      end else if (found) begin
        ack_q[win] <= 1'b1;
        cur_x_q    <= sat_x ? MAX_X_V : sel_x;
        cur_y_q    <= sat_y ? MAX_Y_V : sel_y;
        upd_q      <= 1'b1;
        clp_q      <= sat_x | sat_y;
        rr_q       <= (win == PTR_W'(NUM_REQ-1)) ? '0 : win + 1'b1;
      end
    end
  end

  assign bus.ack        = ack_q;
  assign bus.cur_x      = cur_x_q;
  assign bus.cur_y      = cur_y_q;
  assign bus.out_update = upd_q;
  assign bus.clamped    = clp_q;
endmodule

// File: tb/tb_position_update_arbiter.sv
// Directed scoreboard bench for position_update_arbiter (NUM_REQ=3, MAX_X=3000, MAX_Y=3500).
module tb_position_update_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  position_update_if #(.NUM_REQ(3), .POS_X_BITS(12), .POS_Y_BITS(12)) bus ();

  position_update_arbiter #(
    .NUM_REQ(3), .POS_X_BITS(12), .POS_Y_BITS(12), .MAX_X(3000), .MAX_Y(3500)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic [2:0]  ack;
    logic [11:0] x;
    logic [11:0] y;
    logic        upd;
    logic        clp;
  } exp_t;

  exp_t q[$];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect_out(logic [2:0] a, logic [11:0] x, logic [11:0] y, logic u, logic c);
    exp_t e;
    e.ack = a; e.x = x; e.y = y; e.upd = u; e.clp = c;
    q.push_back(e);
  endtask

  task automatic cycle(string tag);
    exp_t e;
    @(posedge clk);
    #1;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty got 0 entries expected 1", tag);
    end else begin
      e = q.pop_front();
      chk({tag, ".ack"}, 32'(bus.ack), 32'(e.ack));
      chk({tag, ".cur_x"}, 32'(bus.cur_x), 32'(e.x));
      chk({tag, ".cur_y"}, 32'(bus.cur_y), 32'(e.y));
      chk({tag, ".out_update"}, 32'(bus.out_update), 32'(e.upd));
      chk({tag, ".clamped"}, 32'(bus.clamped), 32'(e.clp));
    end
  endtask

  task automatic set_req(int i, logic [11:0] x, logic [11:0] y);
    bus.req_x[i*12 +: 12] = x;
    bus.req_y[i*12 +: 12] = y;
  endtask

  initial begin
    reset = 1'b1;
    bus.req_update = '0;
    bus.req_x = '0;
    bus.req_y = '0;
    bus.hold = 1'b0;
    bus.home = 1'b0;

    expect_out(3'b000, 0, 0, 0, 0); cycle("reset0");
    expect_out(3'b000, 0, 0, 0, 0); cycle("reset1");
    reset = 1'b0;
    expect_out(3'b000, 0, 0, 0, 0); cycle("idle0");

    // single request from requester 1
    set_req(1, 100, 200); bus.req_update = 3'b010;
    expect_out(3'b010, 100, 200, 1, 0); cycle("single");
    bus.req_update = 3'b000;
    expect_out(3'b000, 100, 200, 0, 0); cycle("single_idle");

    // contention from a fresh pointer
    reset = 1'b1;
    expect_out(3'b000, 0, 0, 0, 0); cycle("reset2");
    reset = 1'b0;
    set_req(0, 1, 2); set_req(1, 3, 4); set_req(2, 5, 6);
    bus.req_update = 3'b111;
    expect_out(3'b001, 1, 2, 1, 0); cycle("cont0");
    bus.req_update = 3'b110;
    expect_out(3'b010, 3, 4, 1, 0); cycle("cont1");
    bus.req_update = 3'b100;
    expect_out(3'b100, 5, 6, 1, 0); cycle("cont2");
    bus.req_update = 3'b000;
    expect_out(3'b000, 5, 6, 0, 0); cycle("cont_idle");

    // fairness: 0 and 2 never drop their requests
    set_req(0, 10, 11); set_req(2, 20, 21);
    bus.req_update = 3'b101;
    expect_out(3'b001, 10, 11, 1, 0); cycle("rr0");
    expect_out(3'b100, 20, 21, 1, 0); cycle("rr1");
    expect_out(3'b001, 10, 11, 1, 0); cycle("rr2");
    expect_out(3'b100, 20, 21, 1, 0); cycle("rr3");
    bus.req_update = 3'b000;
    expect_out(3'b000, 20, 21, 0, 0); cycle("rr_idle");

    // clamping per axis; exactly MAX passes through
    set_req(0, 4000, 50); bus.req_update = 3'b001;
    expect_out(3'b001, 3000, 50, 1, 1); cycle("clamp_x");
    bus.req_update = 3'b000;
    expect_out(3'b000, 3000, 50, 0, 0); cycle("clamp_idle0");
    set_req(0, 3000, 3000); bus.req_update = 3'b001;
    expect_out(3'b001, 3000, 3000, 1, 0); cycle("clamp_eq");
    bus.req_update = 3'b000;
    expect_out(3'b000, 3000, 3000, 0, 0); cycle("clamp_idle1");
    set_req(1, 100, 4000); bus.req_update = 3'b010;
    expect_out(3'b010, 100, 3500, 1, 1); cycle("clamp_y");
    bus.req_update = 3'b000;
    expect_out(3'b000, 100, 3500, 0, 0); cycle("clamp_idle2");

    // home beats a simultaneous request, which then wins next cycle
    set_req(0, 10, 10); bus.req_update = 3'b001; bus.home = 1'b1;
    expect_out(3'b000, 0, 0, 1, 0); cycle("home");
    bus.home = 1'b0;
    expect_out(3'b001, 10, 10, 1, 0); cycle("home_after");
    bus.req_update = 3'b000;
    expect_out(3'b000, 10, 10, 0, 0); cycle("home_idle");
    // unchanged position still pulses
    bus.req_update = 3'b001;
    expect_out(3'b001, 10, 10, 1, 0); cycle("same_pos");
    bus.req_update = 3'b000;
    expect_out(3'b000, 10, 10, 0, 0); cycle("same_idle");

    // hold freezes grants; home still acts under hold
    set_req(1, 777, 888); bus.req_update = 3'b010; bus.hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_out(3'b000, 10, 10, 0, 0); cycle("hold");
    end
    bus.home = 1'b1;
    expect_out(3'b000, 0, 0, 1, 0); cycle("hold_home");
    bus.home = 1'b0; bus.hold = 1'b0;
    expect_out(3'b010, 777, 888, 1, 0); cycle("hold_release");

    // reset in the ack cycle with the request still held
    reset = 1'b1;
    expect_out(3'b000, 0, 0, 0, 0); cycle("reset_mid");
    reset = 1'b0; bus.req_update = 3'b000;
    expect_out(3'b000, 0, 0, 0, 0); cycle("reset_idle");
    // pointer back at 0: requester 1 beats 2
    set_req(1, 1, 1); set_req(2, 2, 2); bus.req_update = 3'b110;
    expect_out(3'b010, 1, 1, 1, 0); cycle("rr_after_reset");
    bus.req_update = 3'b000;
    expect_out(3'b000, 1, 1, 0, 0); cycle("final_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
